sha256_msg_padder: RTL

Streams a raw message of 32-bit words into SHA-256 padded 512-bit blocks, emitted one word at a time, for consumption by the SHA-256 compression core. It sits directly upstream of the hash core. It appends the `0x80000000` marker word, zero fill and the 64-bit big-endian bit length, so the core only ever sees complete 16-word blocks. Word-aligned messages only: no partial bytes.

---
 rtl/sha256_msg_padder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
//   Turns a word-aligned message of N 32-bit words into SHA-256 padded
//   512-bit blocks, streamed one word per handshake. It appends the
//   0x80000000 marker word, the zero fill and the 64-bit big-endian bit
//   length. The downstream hash core therefore only ever sees complete
//   16-word blocks.
//
//   Optional build macro SHA_PADDER_BSWAP_EN: when defined, message words are
//   byte-reversed on the pass-through path, for little-endian message memory.
//   Marker, zero and length words are never swapped.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high reset
//   start        one-cycle request, sampled only while idle
//   msg_words    message length N in words, latched on an accepted start
//   in_valid     message word available
//   in_ready     padder consumes in_data this cycle
//   in_data      message word
//   out_valid    padded word available
//   out_ready    downstream accepts out_data
//   out_data     padded word
//   out_blk_end  out_valid qualifier for word 15 of every block
//   out_msg_end  out_valid qualifier for the final word of the message
//   busy         high from the accepted start until the last word is accepted
//   done         one-cycle pulse after the final word handshake
module sha256_msg_padder #(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LEN_W-1:0] msg_words,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             out_blk_end,
   output logic             out_msg_end,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAD  = 2'd2
   } state_t;

   localparam logic [LEN_W:0] K_ONE    = (LEN_W+1)'(1);
   localparam logic [LEN_W:0] K_18     = (LEN_W+1)'(18);
   localparam logic [LEN_W:0] BLK_MASK = ~((LEN_W+1)'(15));

   state_t         state_q, state_d;
   logic [LEN_W:0] k_q, k_d;        // index of the word currently offered
   logic [LEN_W:0] n_q, n_d;        // latched message length N
   logic [LEN_W:0] last_q, last_d;  // index of the final word, T-1
   logic           done_q, done_d;

   logic [LEN_W:0] n_ext;
   logic [LEN_W:0] last_calc;
   logic [31:0]    msg_word;
   logic [31:0]    len_word;

   assign n_ext = {1'b0, msg_words};

   // T = 16*floor((N+18)/16). Clearing the low four bits of N+18 rounds it
   // down to a multiple of 16. The extra counter bit keeps N+18 from wrapping.
   assign last_calc = ((n_ext + K_18) & BLK_MASK) - K_ONE;

   // The bit length fits in 32 bits, so the high length word is always zero.
   assign len_word = 32'(n_q) << 5;

`ifdef SHA_PADDER_BSWAP_EN
   assign msg_word = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
   assign msg_word = in_data;
`endif

   // NOTE: every signal written in this block gets a default first, so no
   // path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      n_d       = n_q;
      last_d    = last_q;
      done_d    = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = 32'h0;

      case (state_q)
         IDLE: begin
            if (start) begin
               n_d     = n_ext;
               last_d  = last_calc;
               k_d     = '0;
               state_d = (msg_words != '0) ? DATA : PAD;
            end
         end

         DATA: begin
            // Zero-latency pass-through. Back-pressure goes straight upstream.
            out_valid = in_valid;
            in_ready  = out_ready;
            out_data  = msg_word;
            if (in_valid && out_ready) begin
               k_d = k_q + K_ONE;
               if (k_q == n_q - K_ONE) begin
                  state_d = PAD;
               end
            end
         end

         PAD: begin
            out_valid = 1'b1;
            if (k_q == n_q) begin
               out_data = 32'h8000_0000;
            end else if (k_q == last_q) begin
               out_data = len_word;
            end
            if (out_ready) begin
               if (k_q == last_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  k_d = k_q + K_ONE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         k_q     <= '0;
         n_q     <= '0;
         last_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         n_q     <= n_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   assign out_blk_end = out_valid & (k_q[3:0] == 4'hF);
   assign out_msg_end = out_valid & (k_q == last_q);
   assign busy        = (state_q != IDLE);
   assign done        = done_q;

endmodule
